// File: rtl/tlc_pkg.sv
// Shared types and helpers for the multi-phase traffic light controller family.
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED   = 3'd0,
        ST_GREEN     = 3'd1,
        ST_YELLOW    = 3'd2,
        ST_FLASH_ON  = 3'd3,
        ST_FLASH_OFF = 3'd4
    } tlc_state_e;

    // Width of a phase index; a single bit is kept even for two phases.
    function automatic int phase_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tlc_phase_arbiter.sv
// Round-robin next-phase selection; optionally skips phases without demand.
module tlc_phase_arbiter
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int SKIP_EMPTY = 0,
    parameter int PW         = phase_w(NUM_PHASES)
) (
    input  logic [PW-1:0]         cur_phase,
    input  logic [NUM_PHASES-1:0] demand,
    output logic [PW-1:0]         next_phase
);

    logic          found;
    logic [PW-1:0] idx;

    // Searching k = 1..NUM_PHASES visits the current phase last, so a lone
    // demand on the phase that just ran gives it right-of-way again.
    always_comb begin
        next_phase = PW'((int'(cur_phase) + 1) % NUM_PHASES);
        found      = 1'b0;
        idx        = '0;
        if (SKIP_EMPTY != 0) begin
            for (int k = 1; k <= NUM_PHASES; k++) begin
                idx = PW'((int'(cur_phase) + k) % NUM_PHASES);
                if (!found && demand[idx]) begin
                    next_phase = idx;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// Round-robin multi-phase signal controller with pedestrian service and flashing-red mode.
module multi_phase_traffic_controller
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 5,
    parameter int FLASH_HALF = 4,
    parameter int SKIP_EMPTY = 0,
    parameter int CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PHASES-1:0]          ped_req,
    input  logic [NUM_PHASES-1:0]          veh_det,
    input  logic                           flash_mode,
    output logic [NUM_PHASES-1:0]          red,
    output logic [NUM_PHASES-1:0]          yellow,
    output logic [NUM_PHASES-1:0]          green,
    output logic [NUM_PHASES-1:0]          ped_walk,
    output logic [phase_w(NUM_PHASES)-1:0] cur_phase,
    output logic [NUM_PHASES-1:0]          ped_pending
);

    localparam int PW = phase_w(NUM_PHASES);
    localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] WALK_END = CNT_W'(GREEN_CYC - WALK_CYC);

    tlc_state_e            state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic                  home_q, home_d;
    logic                  flash_req_q, flash_req_d;
    logic                  serve_q, serve_d;
    logic                  timeout;
    logic [PW-1:0]         phase_d, arb_next;
    logic [NUM_PHASES-1:0] demand, pend_seen, pend_d;
    logic [NUM_PHASES-1:0] red_d, yellow_d, green_d, walk_d;

    assign demand  = veh_det | ped_pending;
    assign timeout = (timer_q == '0);

    tlc_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES),
        .SKIP_EMPTY (SKIP_EMPTY),
        .PW         (PW)
    ) u_arb (
        .cur_phase  (cur_phase),
        .demand     (demand),
        .next_phase (arb_next)
    );

    // home_q forces phase 0 as the first green after reset or flash exit;
    // flash_req_q remembers a flash request until the clearance completes.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q - CNT_W'(1);
        home_d      = home_q;
        flash_req_d = flash_req_q | flash_mode;
        serve_d     = serve_q;
        phase_d     = cur_phase;
        pend_seen   = ped_pending | ped_req;
        pend_d      = pend_seen;
        case (state_q)
            ST_GREEN: begin
                if (flash_mode || timeout) begin
                    state_d = ST_YELLOW;
                    timer_d = T_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timeout) begin
                    state_d = ST_ALL_RED;
                    timer_d = T_ALLRED;
                end
            end
            ST_ALL_RED: begin
                if (timeout) begin
                    if (flash_req_q || flash_mode) begin
                        state_d     = ST_FLASH_ON;
                        timer_d     = T_FLASH;
                        flash_req_d = 1'b0;
                    end else begin
                        state_d         = ST_GREEN;
                        timer_d         = T_GREEN;
                        phase_d         = home_q ? '0 : arb_next;
                        home_d          = 1'b0;
                        serve_d         = pend_seen[phase_d];
                        pend_d[phase_d] = 1'b0;
                    end
                end
            end
            ST_FLASH_ON, ST_FLASH_OFF: begin
                flash_req_d = 1'b0;
                if (timeout) begin
                    if (flash_mode) begin
                        state_d = (state_q == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
                        timer_d = T_FLASH;
                    end else begin
                        state_d = ST_ALL_RED;
                        timer_d = T_ALLRED;
                        home_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                timer_d = T_ALLRED;
            end
        endcase
    end

    // Lamps are decoded from the next state so they are registered with it.
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        walk_d   = '0;
        case (state_d)
            ST_GREEN: begin
                green_d[phase_d] = 1'b1;
                red_d[phase_d]   = 1'b0;
                walk_d[phase_d]  = serve_d && (timer_d >= WALK_END);
            end
            ST_YELLOW: begin
                yellow_d[phase_d] = 1'b1;
                red_d[phase_d]    = 1'b0;
            end
            ST_FLASH_OFF: red_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ALL_RED;
            timer_q     <= T_ALLRED;
            home_q      <= 1'b1;
            flash_req_q <= 1'b0;
            serve_q     <= 1'b0;
            cur_phase   <= '0;
            ped_pending <= '0;
            red         <= '1;
            yellow      <= '0;
            green       <= '0;
            ped_walk    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            home_q      <= home_d;
            flash_req_q <= flash_req_d;
            serve_q     <= serve_d;
            cur_phase   <= phase_d;
            ped_pending <= pend_d;
            red         <= red_d;
            yellow      <= yellow_d;
            green       <= green_d;
            ped_walk    <= walk_d;
        end
    end

endmodule

// File: doc/multi_phase_traffic_controller.md
Name: multi_phase_traffic_controller

Overview:
- Parametrised successor to the single-approach traffic light controller.
- Sequences NUM_PHASES signal groups round-robin. Each phase runs GREEN, then YELLOW, then ALL_RED clearance.
- Per-phase pedestrian requests are latched and served with a WALK window at the start of that phase's green. Optional skipping of phases with no demand.
- Has a safe flashing-red mode for fault or night operation. Sits at intersection top level; outputs drive lamp drivers directly.

Parameters:
- NUM_PHASES, 4, number of signal groups (2..8)
- GREEN_CYC, 8, green duration in clk cycles (>= WALK_CYC, >= 1)
- YELLOW_CYC, 3, yellow duration in cycles (>= 1)
- ALLRED_CYC, 2, all-red clearance in cycles (>= 1)
- WALK_CYC, 5, ped_walk duration in cycles (1..GREEN_CYC)
- FLASH_HALF, 4, half-period of flashing red in cycles (>= 1)
- SKIP_EMPTY, 0, 1 = skip phases with no vehicle or ped demand
- CNT_W, 8, timer width; must hold max of all *_CYC values

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ped_req  in  NUM_PHASES  pedestrian button per phase, level or pulse
- veh_det  in  NUM_PHASES  vehicle presence per phase; used only when SKIP_EMPTY=1
- flash_mode  in  1  request flashing-red operation
- red  out  NUM_PHASES  red lamp per phase
- yellow  out  NUM_PHASES  yellow lamp per phase
- green  out  NUM_PHASES  green lamp per phase
- ped_walk  out  NUM_PHASES  walk signal per phase
- cur_phase  out  $clog2(NUM_PHASES)  phase currently owning right-of-way
- ped_pending  out  NUM_PHASES  latched, unserved ped requests

Behaviour:
- Reset (reset_n=0, async):
  - State ALL_RED, timer = ALLRED_CYC-1, cur_phase = 0, next phase = 0.
  - red all ones. yellow, green, ped_walk, ped_pending all zero.
- States: ALL_RED, GREEN, YELLOW, FLASH_ON, FLASH_OFF. Every state lasts exactly its *_CYC cycles; the timer counts down and the transition occurs when the timer is 0.
- After reset release: ALLRED_CYC all-red cycles, then GREEN on phase 0.
- GREEN(p): green[p]=1, red[p]=0. All other phases red. At timeout go to YELLOW(p).
- YELLOW(p): yellow[p]=1, all others red. At timeout go to ALL_RED.
- ALL_RED: all red. At timeout go to GREEN of the selected next phase.
- Next-phase selection, evaluated in the last ALL_RED cycle:
  - SKIP_EMPTY=0: (cur+1) mod NUM_PHASES.
  - SKIP_EMPTY=1: first phase after cur, in round-robin order, with veh_det or ped_pending set. If no phase has demand, use (cur+1) mod NUM_PHASES.
- Exactly one of red/yellow/green per phase is 1 outside FLASH. At most one phase is non-red at any time.
- Ped latch: ped_pending[i] sets on any cycle with ped_req[i]=1.
  - It clears on the cycle GREEN(i) is entered if it was set at entry; that green then asserts ped_walk[i] for its first WALK_CYC cycles.
  - A request arriving after green entry stays latched for the next service of phase i.
  - ped_walk is 0 in all other states.
- Flash entry: flash_mode sampled every cycle.
  - If asserted during GREEN, the current green truncates to YELLOW next cycle, then runs full YELLOW_CYC, then full ALL_RED, then FLASH_ON.
  - If asserted during YELLOW or ALL_RED, the state completes normally, then goes to FLASH_ON. Green is never entered while flash_mode=1.
- FLASH_ON: all red=1. FLASH_OFF: all red=0. Each lasts FLASH_HALF cycles. Yellow, green and ped_walk are 0.
- Flash exit: flash_mode=0 is sampled at the end of a flash half-period. Go to ALL_RED for ALLRED_CYC, then GREEN of phase 0. ped_pending is retained.
- Reset mid-operation forces the reset state immediately (async), regardless of current state.
- cur_phase updates on GREEN entry and holds through YELLOW, ALL_RED and FLASH.
- All outputs are registered; no combinational path from inputs to lamp outputs.

Decomposition:
- Shared package tlc_pkg: state enum (ALL_RED, GREEN, YELLOW, FLASH_ON, FLASH_OFF) and a phase-index width function.
- One sub-module: tlc_phase_arbiter. Round-robin next-phase selection from cur_phase, the demand vector and SKIP_EMPTY; combinational; reused by future multi-ring variants.

Test Plan (defaults: NUM_PHASES=4, GREEN 8, YELLOW 3, ALLRED 2, WALK 5, reset released at cycle 0):
- Reset and sequencing: all red cycles 0-1; green[0] cycles 2-9; yellow[0] cycles 10-12; all red 13-14; green[1] at cycle 15; after phase 3, phase 0 again.
- Ped service: ped_req[1] pulsed 1 cycle at cycle 4 → ped_pending[1]=1 through cycle 14; cycle 15 ped_pending[1] clears; ped_walk[1]=1 cycles 15-19, 0 from cycle 20.
- Late ped: ped_req[1] at cycle 17 (during green[1]) → no walk this green; ped_pending[1] stays 1; walk on next green[1] at cycle 67.
- Skip: SKIP_EMPTY=1, veh_det=4'b1000, no ped → after phase 0, green[3] follows at cycle 15; phases 1-2 never green.
- Flash: flash_mode=1 at cycle 5 → yellow[0] cycles 6-8; all red 9-10; red toggles every 4 cycles from cycle 11. Deassert flash → ALL_RED 2 cycles after current half-period ends, then green[0].
- Async reset during yellow[2] → outputs return to reset values within the same cycle, with no clk edge needed; sequence restarts at phase 0.
